// File: rtl/uart_alu_packet_engine_if.sv
// Purpose : RX/TX byte-stream handshake bundle between the UART ALU packet engine and the UART receiver/transmitter.
// Latency : none (wires only).
// Backpr. : rx_ready_o / tx_ready_i carry valid-ready backpressure on each byte path.
// Signals : rx_data_i/rx_valid_i/rx_ready_o = receive byte path into the engine,
//           tx_data_o/tx_valid_o/tx_ready_i = transmit byte path out of the engine.
// Modports: slave = engine side, master = UART / environment side.
interface uart_alu_packet_engine_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;

  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    output rx_ready_o, tx_data_o, tx_valid_o
  );

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i,
    input  rx_ready_o, tx_data_o, tx_valid_o
  );
endinterface

// File: rtl/uart_alu_packet_engine.sv
// Purpose : parses UART ALU command packets (opcode, rsvd, len lo/hi, payload) and runs echo / add / multiply.
// Latency : echo is combinational pass-through; add/mul result byte 0 appears the cycle after the last payload byte.
// Backpr. : echo ties rx_ready to tx_ready; result bytes are registered and held while tx_ready_i is low.
// Ports   : clk_i, rst_i (sync, active-high); bus (uart_alu_packet_engine_if.slave) rx/tx byte paths;
//           busy_o = packet in progress; err_o = one-cycle pulse on short length or unknown opcode.
// Config  : define UART_ALU_MUL_EN to build the multiplier (opcode 0x88); otherwise 0x88 is unknown.
module uart_alu_packet_engine #(
  parameter int OPERAND_BYTES = 4,
  parameter int LEN_W         = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  uart_alu_packet_engine_if.slave bus,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int OW    = 8 * OPERAND_BYTES;
  localparam int IDX_W = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;

  localparam logic [7:0]       OP_ECHO = 8'hEC;
  localparam logic [7:0]       OP_ADD  = 8'hAD;
`ifdef UART_ALU_MUL_EN
  localparam logic [7:0]       OP_MUL  = 8'h88;
`endif
  localparam logic [LEN_W-1:0] HDR_LEN = LEN_W'(4);

  typedef enum logic [2:0] {
    S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_ECHO, S_ACC, S_DRAIN, S_RESULT
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       opcode_q;
  logic [7:0]       len_lo_q;
  logic [LEN_W-1:0] count_q;      // payload bytes still to come
  logic [OW-1:0]    opnd_q;       // operand under assembly, upper bytes kept zero
  logic [OW-1:0]    acc_q;
  logic             have_acc_q;   // first complete operand loads instead of combining
  logic [IDX_W-1:0] byte_idx_q;
  logic [IDX_W-1:0] res_idx_q;
  logic [7:0]       tx_dat_q;
  logic             tx_vld_q;
  logic             err_q;

  logic             rx_ready, rx_fire;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic [LEN_W-1:0] len_full, payload;
  logic             len_short, op_known, op_is_acc;
  logic [OW-1:0]    opnd_next, acc_next;
  logic             opnd_done, last_byte, res_last;
  logic [IDX_W-1:0] res_idx_inc;

  // Header decode
  assign len_full  = LEN_W'({bus.rx_data_i, len_lo_q});
  assign len_short = len_full < HDR_LEN;
  assign payload   = len_full - HDR_LEN;

`ifdef UART_ALU_MUL_EN
  assign op_is_acc = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
`else
  assign op_is_acc = (opcode_q == OP_ADD);
`endif
  assign op_known  = op_is_acc || (opcode_q == OP_ECHO);

  // Operand assembly: little-endian byte insert; a trailing partial operand
  // is applied on the last payload byte with its missing upper bytes still zero.
  assign opnd_next = opnd_q | (OW'(bus.rx_data_i) << {byte_idx_q, 3'b000});
  assign last_byte = (count_q == LEN_W'(1));
  assign opnd_done = (byte_idx_q == IDX_W'(OPERAND_BYTES - 1)) || last_byte;

  always_comb begin
    acc_next = opnd_next;
    if (have_acc_q) begin
`ifdef UART_ALU_MUL_EN
      if (opcode_q == OP_MUL) acc_next = acc_q * opnd_next;
      else                    acc_next = acc_q + opnd_next;
`else
      acc_next = acc_q + opnd_next;
`endif
    end
  end

  assign res_last    = (res_idx_q == IDX_W'(OPERAND_BYTES - 1));
  assign res_idx_inc = res_idx_q + IDX_W'(1);

  // Next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b1;
    tx_data  = tx_dat_q;
    tx_valid = tx_vld_q;
    rx_fire  = 1'b0;

    case (state_q)
      S_ECHO: begin
        rx_ready = bus.tx_ready_i;
        tx_data  = bus.rx_data_i;
        tx_valid = bus.rx_valid_i;
      end
      S_RESULT: rx_ready = 1'b0;
      default:  rx_ready = 1'b1;
    endcase

    if (rst_i) begin
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
    end

    rx_fire = bus.rx_valid_i && rx_ready;

    case (state_q)
      S_OPCODE: if (rx_fire) state_d = S_RSVD;
      S_RSVD:   if (rx_fire) state_d = S_LEN_LO;
      S_LEN_LO: if (rx_fire) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (rx_fire) begin
          if (len_short)              state_d = S_OPCODE;
          else if (!op_known)         state_d = (payload == '0) ? S_OPCODE : S_DRAIN;
          else if (payload == '0)     state_d = op_is_acc ? S_RESULT : S_OPCODE;
          else                        state_d = op_is_acc ? S_ACC : S_ECHO;
        end
      end
      S_ECHO, S_DRAIN: if (rx_fire && last_byte) state_d = S_OPCODE;
      S_ACC:           if (rx_fire && last_byte) state_d = S_RESULT;
      S_RESULT:        if (bus.tx_ready_i && res_last) state_d = S_OPCODE;
      default:         state_d = S_OPCODE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_OPCODE;
    else       state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opcode_q   <= '0;
      len_lo_q   <= '0;
      count_q    <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      have_acc_q <= 1'b0;
      byte_idx_q <= '0;
      res_idx_q  <= '0;
      tx_dat_q   <= '0;
      tx_vld_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_OPCODE: if (rx_fire) opcode_q <= bus.rx_data_i;
        S_LEN_LO: if (rx_fire) len_lo_q <= bus.rx_data_i;
        S_LEN_HI: begin
          if (rx_fire) begin
            count_q    <= payload;
            opnd_q     <= '0;
            acc_q      <= '0;
            have_acc_q <= 1'b0;
            byte_idx_q <= '0;
            res_idx_q  <= '0;
            if (len_short || !op_known) err_q <= 1'b1;
            // Empty add/mul payload still returns a (zero) result.
            if (!len_short && op_is_acc && payload == '0) begin
              tx_vld_q <= 1'b1;
              tx_dat_q <= 8'h00;
            end
          end
        end
        S_ECHO, S_DRAIN: if (rx_fire) count_q <= count_q - LEN_W'(1);
        S_ACC: begin
          if (rx_fire) begin
            count_q <= count_q - LEN_W'(1);
            if (opnd_done) begin
              acc_q      <= acc_next;
              have_acc_q <= 1'b1;
              opnd_q     <= '0;
              byte_idx_q <= '0;
            end else begin
              opnd_q     <= opnd_next;
              byte_idx_q <= byte_idx_q + IDX_W'(1);
            end
            // Preload result byte 0 so it is valid the very next cycle.
            if (last_byte) begin
              tx_vld_q <= 1'b1;
              tx_dat_q <= acc_next[7:0];
            end
          end
        end
        S_RESULT: begin
          if (bus.tx_ready_i) begin
            if (res_last) begin
              tx_vld_q <= 1'b0;
              tx_dat_q <= 8'h00;
            end else begin
              res_idx_q <= res_idx_inc;
              tx_dat_q  <= 8'(acc_q >> {res_idx_inc, 3'b000});
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready_o = rx_ready;
  assign bus.tx_data_o  = tx_data;
  assign bus.tx_valid_o = tx_valid;
  assign busy_o         = (state_q != S_OPCODE);
  assign err_o          = err_q;

endmodule

// File: tb/tb_uart_alu_packet_engine.sv
// Purpose : randomized and directed bench for uart_alu_packet_engine against a packet-level reference model.
// Latency : checks result/err timing relative to the accepting cycle of the relevant rx byte.
// Backpr. : drives random and forced tx_ready_i stalls and checks tx output stability.
module tb_uart_alu_packet_engine;
  localparam int OB = 4;
`ifdef UART_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef logic [7:0] u8;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic busy_o, err_o;

  uart_alu_packet_engine_if bus ();

  uart_alu_packet_engine #(.OPERAND_BYTES(OB), .LEN_W(16)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .bus    (bus),
    .busy_o (busy_o),
    .err_o  (err_o)
  );

  initial forever #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int fire_cyc = 0;
  u8  got_tx[$];
  int err_cyc_q[$];
  int txv_cyc_q[$];
  bit hold_prev = 1'b0;
  u8  hold_dat  = 8'h00;
  bit prev_txv  = 1'b0;
  int hold_cnt  = 0;
  bit bp_on     = 1'b0;
  bit echo_pl   = 1'b0;
  bit rx_fired  = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample at negedge, advance past posedge, then drive tx_ready.
  task automatic step();
    @(negedge clk);
    rx_fired = bus.rx_valid_i && bus.rx_ready_o;
    if (rx_fired) fire_cyc = cyc;
    if (!rst_i) begin
      if (hold_prev) begin
        check_val("tx_hold_vld", 64'(bus.tx_valid_o), 64'(1));
        check_val("tx_hold_dat", 64'(bus.tx_data_o), 64'(hold_dat));
      end
      if (bus.tx_valid_o && bus.tx_ready_i) got_tx.push_back(bus.tx_data_o);
      if (err_o) err_cyc_q.push_back(cyc);
      if (bus.tx_valid_o && !prev_txv) txv_cyc_q.push_back(cyc);
      if (rx_fired && echo_pl) begin
        check_val("echo_vld", 64'(bus.tx_valid_o), 64'(1));
        check_val("echo_dat", 64'(bus.tx_data_o), 64'(bus.rx_data_i));
      end
    end
    hold_prev = !rst_i && bus.tx_valid_o && !bus.tx_ready_i;
    hold_dat  = bus.tx_data_o;
    prev_txv  = bus.tx_valid_o && !rst_i;
    @(posedge clk);
    cyc++;
    #1;
    if (hold_cnt > 0 && bus.tx_valid_o) begin
      bus.tx_ready_i = 1'b0;
      hold_cnt--;
    end else begin
      bus.tx_ready_i = bp_on ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  // Packet-level reference: operands are OB-byte little-endian chunks of the payload.
  function automatic void model(input u8 pkt[$], output u8 exp[$], output int exp_err, output bit is_res);
    int len, pl;
    longint unsigned mask, acc, v;
    exp = {};
    exp_err = 0;
    is_res = 1'b0;
    len = int'(pkt[2]) + 256 * int'(pkt[3]);
    if (len < 4) begin
      exp_err = 1;
      return;
    end
    pl = len - 4;
    mask = (OB == 8) ? ~64'd0 : ((64'd1 << (8 * OB)) - 64'd1);
    if (pkt[0] == 8'hEC) begin
      for (int i = 0; i < pl; i++) exp.push_back(pkt[4 + i]);
    end else if (pkt[0] == 8'hAD || (pkt[0] == 8'h88 && MUL_EN)) begin
      is_res = 1'b1;
      acc = 0;
      for (int k = 0; k * OB < pl; k++) begin
        v = 0;
        for (int b = 0; b < OB && k * OB + b < pl; b++)
          v = v + (64'(pkt[4 + k * OB + b]) << (8 * b));
        if (k == 0)              acc = v;
        else if (pkt[0] == 8'hAD) acc = (acc + v) & mask;
        else                     acc = (acc * v) & mask;
      end
      for (int b = 0; b < OB; b++) exp.push_back(u8'(acc >> (8 * b)));
    end else begin
      exp_err = 1;
    end
  endfunction

  task automatic send_bytes(input u8 pkt[$], input bit echo, output int acc_cyc[$]);
    int budget;
    acc_cyc = {};
    foreach (pkt[i]) begin
      bus.rx_valid_i = 1'b0;
      echo_pl = 1'b0;
      repeat ($urandom_range(0, 1) * $urandom_range(0, 3)) step();
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = pkt[i];
      echo_pl = echo && (i >= 4);
      rx_fired = 1'b0;
      budget = 0;
      while (!rx_fired && budget < 200) begin
        step();
        budget++;
      end
      if (!rx_fired) begin
        check_val("rx_accept", 64'(rx_fired), 64'(1));
        break;
      end
      acc_cyc.push_back(fire_cyc);
    end
    bus.rx_valid_i = 1'b0;
    echo_pl = 1'b0;
  endtask

  task automatic run_pkt(input u8 pkt[$], input bit hold5);
    u8  exp[$];
    int exp_err, b_tx, b_err, b_txv, budget, n_got;
    int acc_cyc[$];
    bit is_res, echo;
    model(pkt, exp, exp_err, is_res);
    b_tx  = got_tx.size();
    b_err = err_cyc_q.size();
    b_txv = txv_cyc_q.size();
    echo  = (pkt[0] == 8'hEC) && (exp_err == 0);
    if (hold5) hold_cnt = 5;
    send_bytes(pkt, echo, acc_cyc);
    budget = 0;
    while ((busy_o || got_tx.size() - b_tx < exp.size()) && budget < 500) begin
      step();
      budget++;
    end
    check_val("pkt_timeout", 64'(budget < 500), 64'(1));
    repeat (4) step();
    hold_cnt = 0;
    n_got = got_tx.size() - b_tx;
    check_val("tx_count", 64'(n_got), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < n_got; i++)
      check_val("tx_byte", 64'(got_tx[b_tx + i]), 64'(exp[i]));
    check_val("err_pulses", 64'(err_cyc_q.size() - b_err), 64'(exp_err));
    if (exp_err != 0 && err_cyc_q.size() > b_err && acc_cyc.size() >= 4)
      check_val("err_timing", 64'(err_cyc_q[b_err]), 64'(acc_cyc[3] + 1));
    if (is_res) begin
      if (txv_cyc_q.size() > b_txv)
        check_val("res_latency", 64'(txv_cyc_q[b_txv]), 64'(acc_cyc[acc_cyc.size() - 1] + 1));
      else
        check_val("res_seen", 64'(txv_cyc_q.size() - b_txv), 64'(1));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    u8  p[$];
    int ac[$];
    int sel, pl;
    u8  op;

    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.tx_ready_i = 1'b1;
    rst_i = 1'b1;
    repeat (3) step();
    check_val("rst_tx_valid", 64'(bus.tx_valid_o), 64'(0));
    check_val("rst_tx_data",  64'(bus.tx_data_o),  64'(0));
    check_val("rst_err",      64'(err_o),          64'(0));
    check_val("rst_busy",     64'(busy_o),         64'(0));
    check_val("rst_rx_ready", 64'(bus.rx_ready_o), 64'(0));
    rst_i = 1'b0;
    step();
    check_val("idle_rx_ready", 64'(bus.rx_ready_o), 64'(1));

    // Directed cases
    p = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h42, 8'h69, 8'h42, 8'h69};
    run_pkt(p, 1'b0);
    check_val("echo_busy_after", 64'(busy_o), 64'(0));
    p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h42, 8'h69, 8'h42, 8'h69, 8'h42, 8'h69, 8'h42, 8'h69};
    run_pkt(p, 1'b0);
    p = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_pkt(p, 1'b0);
    p = '{8'hAD, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
    run_pkt(p, 1'b0);
    p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    run_pkt(p, 1'b0);
    p = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    run_pkt(p, 1'b0);
    p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h5A, 8'hA5};
    run_pkt(p, 1'b0);
    p = '{8'hAD, 8'h00, 8'h02, 8'h00};
    run_pkt(p, 1'b0);
    p = '{8'hAD, 8'h00, 8'h04, 8'h00};
    run_pkt(p, 1'b0);
    p = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_pkt(p, 1'b1);
    p = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    run_pkt(p, 1'b0);

    // Reset in the middle of an ADD payload
    p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22};
    send_bytes(p, 1'b0, ac);
    check_val("mid_busy", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    step();
    check_val("mid_rst_tx_valid", 64'(bus.tx_valid_o), 64'(0));
    check_val("mid_rst_tx_data",  64'(bus.tx_data_o),  64'(0));
    check_val("mid_rst_busy",     64'(busy_o),         64'(0));
    check_val("mid_rst_err",      64'(err_o),          64'(0));
    check_val("mid_rst_rx_ready", 64'(bus.rx_ready_o), 64'(0));
    rst_i = 1'b0;
    step();
    check_val("mid_idle_rx_ready", 64'(bus.rx_ready_o), 64'(1));
    p = '{8'hAD, 8'h00, 8'h0B, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h01, 8'h02, 8'h03};
    run_pkt(p, 1'b0);

    // Random packets, random gaps and backpressure
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       op = 8'hEC;
        1, 4:    op = 8'hAD;
        2:       op = 8'h88;
        default: begin
          op = u8'($urandom_range(0, 255));
          if (op == 8'hEC || op == 8'hAD || op == 8'h88) op = 8'h00;
        end
      endcase
      p = {};
      p.push_back(op);
      p.push_back(u8'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        p.push_back(u8'($urandom_range(0, 3)));
        p.push_back(8'h00);
      end else begin
        pl = $urandom_range(0, 13);
        p.push_back(u8'(pl + 4));
        p.push_back(8'h00);
        for (int i = 0; i < pl; i++) p.push_back(u8'($urandom));
      end
      bp_on = ($urandom_range(0, 1) == 1);
      run_pkt(p, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_alu_packet_engine.md
# uart_alu_packet_engine

Byte-stream packet engine that parses UART ALU command packets from the RX byte path, executes echo/add/multiply operations and returns results on the TX byte path. Sits between the UART receiver and transmitter inside the UART ALU top level. Operand width and length-field width are parametrised; it handles arbitrary operand counts, partial trailing operands and malformed or unknown packets.

## Interface
- OPERAND_BYTES, 4: operand/result width in bytes (operand width = 8*OPERAND_BYTES bits); legal 1–8.
- LEN_W, 16: packet length field width in bits; must be 16.
- clk_i  in  1  single clock.
- rst_i  in  1  reset, synchronous, active-high.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  rx_data_i valid.
- rx_ready_o  out  1  engine accepts byte this cycle.
- tx_data_o  out  8  byte to transmit.
- tx_valid_o  out  1  tx_data_o valid.
- tx_ready_i  in  1  transmitter accepts byte.
- busy_o  out  1  packet in progress (state != OPCODE).
- err_o  out  1  one-cycle pulse on malformed/unknown packet.

## Operation
- Packet: byte0 opcode, byte1 reserved (ignored), byte2 length LSB, byte3 length MSB, then payload. Length counts all bytes including the 4-byte header; payload = length − 4.
- Opcodes: 0xEC ECHO, 0xAD ADD, 0x88 MUL (see Configuration). Anything else is unknown.
- States: OPCODE → RSVD → LEN_LO → LEN_HI → {ECHO, ACC, DRAIN} → (RESULT) → OPCODE. Each header state advances on rx_valid_i && rx_ready_o.
- From LEN_HI: length < 4 → err_o pulse, back to OPCODE. Unknown opcode → err_o pulse, DRAIN if payload > 0 else OPCODE. Payload 0: ECHO → OPCODE; ADD/MUL → RESULT with result 0.
- ECHO: pass-through; tx_data_o = rx_data_i, tx_valid_o = rx_valid_i, rx_ready_o = tx_ready_i. Count transfers; after last payload byte → OPCODE.
- ACC: bytes assembled little-endian into an operand register; first complete operand loads accumulator, each later operand is added (ADD) or multiplied (MUL) into it, truncated mod 2^(8*OPERAND_BYTES). A trailing partial operand is zero-extended in its upper bytes and then applied. After last payload byte → RESULT.
- RESULT: emit OPERAND_BYTES accumulator bytes, LSB first; rx_ready_o = 0. After final byte accepted → OPCODE.
- DRAIN: rx_ready_o = 1, discard payload, → OPCODE when count exhausted.
- Reset mid-packet: state → OPCODE, counters/accumulator cleared; subsequent bytes are parsed as a new header.

## Timing
- Reset values: tx_valid_o 0, tx_data_o 0x00, err_o 0, busy_o 0; rx_ready_o 0 while rst_i high, 1 in OPCODE after.
- rx_ready_o = 1 in OPCODE, RSVD, LEN_LO, LEN_HI, ACC, DRAIN; 0 in RESULT.
- err_o asserted exactly the cycle after the LEN_HI byte is accepted.
- RESULT latency: last payload byte (or LEN_HI for zero payload) accepted in cycle N → tx_valid_o = 1 with result byte 0 in cycle N+1.
- RESULT outputs registered; tx_data_o/tx_valid_o held stable while tx_ready_i low; one byte per cycle at full rate.
- ECHO path combinational: zero-cycle latency, full throughput.
- Accumulation one operand per cycle; no rx stall in ACC.

## Configuration
- UART_ALU_MUL_EN defined: opcode 0x88 performs truncated multiply accumulation as above.
- Undefined: multiplier not built; 0x88 is an unknown opcode (err_o pulse, payload drained, no TX output).

## Test plan
- ECHO: EC 00 08 00 42 69 42 69 → TX 42 69 42 69, err_o never high, busy_o low after.
- ADD: AD 00 0C 00 42 69 42 69 42 69 42 69 → TX 84 D2 84 D2 (0x69426942 × 2).
- ADD wrap + partial: AD 00 08 00 FF FF FF FF then AD 00 07 00 01 02 03 → TX FF FF FF FF then 01 02 03 00; second: AD 00 0C 00 FF FF FF FF 02 00 00 00 → TX 01 00 00 00.
- Error: 55 00 06 00 AA BB → err_o one pulse, no TX, bytes drained; following echo packet returns payload correctly; length 0x0002 → err_o, immediate OPCODE.
- Backpressure/reset: hold tx_ready_i low 5 cycles during RESULT → tx_data_o stable; assert rst_i after 2 payload bytes → outputs return to reset values, next full ADD packet correct.
- MUL: 88 00 0C 00 03 00 00 00 05 00 00 00 → with UART_ALU_MUL_EN TX 0F 00 00 00; without → err_o pulse, no TX.
